net_rx_iface: RTL and testbench
===============================

NET_RX_IFACE -- requirements
Module: net_rx_iface

Interface
REQ-001 SHALL have parameter DEPTH, default 4, payload FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of the drop counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous reset, active-low (rst==0 at posedge clk resets).
REQ-005 SHALL have port my_x  input  16  this node's mesh column (1-based, same encoding as router coordinates).
REQ-006 SHALL have port my_y  input  16  this node's mesh row.
REQ-007 SHALL have port pkt_in  input  64  packet from router local output: [63:48] dst_x, [47:32] dst_y, [31:0] payload.
REQ-008 SHALL have port pkt_valid  input  1  pkt_in holds a packet this cycle.
REQ-009 SHALL have port pkt_ready  output  1  block accepts a packet this cycle.
REQ-010 SHALL have port cpu_data  output  32  payload delivered to the CPU input port.
REQ-011 SHALL have port cpu_valid  output  1  cpu_data holds a delivered payload.
REQ-012 SHALL have port cpu_ready  input  1  CPU consumes cpu_data this cycle.
REQ-013 SHALL have port flush  input  1  synchronous discard of all buffered payloads.
REQ-014 SHALL have port fifo_count  output  $clog2(DEPTH)+1  number of buffered payloads (including the one on cpu_data).
REQ-015 SHALL have port drop_cnt  output  CNT_W  saturating count of misaddressed packets dropped.

Function
REQ-016 SHALL accept a packet when pkt_valid && pkt_ready at posedge clk (NoC handshake).
REQ-017 SHALL drive pkt_ready = (fifo_count < DEPTH) && !flush, derived from registered count only; no same-cycle bypass from cpu_ready.
REQ-018 SHALL, on acceptance with dst_x==my_x and dst_y==my_y, push payload [31:0] into the FIFO tail.
REQ-019 SHALL, on acceptance with address mismatch, discard the packet, not change the FIFO, and increment drop_cnt, saturating at 2^CNT_W-1.
REQ-020 SHALL present the FIFO head on cpu_data with cpu_valid=1 whenever fifo_count>0; cpu_data undefined-but-stable (hold last) when cpu_valid=0.
REQ-021 SHALL pop the head when cpu_valid && cpu_ready at posedge clk; cpu_data/cpu_valid hold unchanged while cpu_valid && !cpu_ready.
REQ-022 SHALL have latency 1: payload accepted at edge N into empty FIFO appears with cpu_valid=1 after edge N.
REQ-023 SHALL, on simultaneous push and pop, keep fifo_count unchanged and preserve FIFO order.
REQ-024 SHALL wrap read/write pointers modulo DEPTH; order is strict FIFO across wrap.
REQ-025 SHALL, when flush=1 at an edge, clear FIFO (count 0, pointers 0, cpu_valid 0), ignore any same-cycle pop; drop_cnt unaffected; pkt_ready=0 that cycle.
REQ-026 SHALL treat pkt_valid with pkt_ready=0 as not accepted: no push, no drop count; sender holds.
REQ-027 SHALL track occupancy with states EMPTY (count 0), PARTIAL, FULL (count DEPTH); transitions only via push/pop/flush per REQ-018..025.

Reset
REQ-028 SHALL, when rst==0 at posedge clk, set fifo_count=0, pointers=0, cpu_valid=0, cpu_data=0, drop_cnt=0; pkt_ready=0 during that cycle.
REQ-029 SHALL discard any in-progress handshake on reset; a packet presented in the reset cycle is not accepted.
REQ-030 SHALL drive pkt_ready=1 in the first cycle after rst returns to 1.

Verification
REQ-031 SHALL cover: my=(2,2), send pkt 0x0002_0002_DEADBEEF, cpu_ready=1 -> cpu_valid=1, cpu_data=0xDEADBEEF one cycle later, then count 0.
REQ-032 SHALL cover: my=(2,2), send 0x0003_0002_12345678 -> no cpu_valid, drop_cnt=1; 300 mismatches -> drop_cnt=255.
REQ-033 SHALL cover: cpu_ready=0, send 5 matching payloads 1..5 back-to-back -> 4 accepted, pkt_ready=0, count=4; raise cpu_ready -> outputs 1,2,3,4 in order, 5th accepted after first pop.
REQ-034 SHALL cover: count=2, push and pop same edge -> count stays 2, order preserved across 10 wrap-around cycles.
REQ-035 SHALL cover: count=3, assert flush with cpu_ready=1 -> count=0, cpu_valid=0, drop_cnt unchanged next cycle.
REQ-036 SHALL cover: rst=0 mid-stream with count=3, drop_cnt=7 -> all outputs zero after the edge, pkt_ready=1 the cycle after release.

Source files
------------

// File: rtl/net_rx_iface.sv
// NoC receive interface: filters packets by destination,
// buffers payloads in a small FIFO and hands them to the CPU.
module net_rx_iface #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [15:0]              my_x,
   input  logic [15:0]              my_y,
   input  logic [63:0]              pkt_in,
   input  logic                     pkt_valid,
   output logic                     pkt_ready,
   output logic [31:0]              cpu_data,
   output logic                     cpu_valid,
   input  logic                     cpu_ready,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [CNT_W-1:0]         drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      EMPTY,
      PARTIAL,
      FULL
   } occ_t;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_nxt;
   logic [CW-1:0] count;
   logic [CW-1:0] cnt_nxt;
   occ_t          state;
   logic          accept;
   logic          hit;
   logic          push;
   logic          pop;

   assign rd_nxt     = rd_ptr + 1'b1;
   assign fifo_count = count;
   assign cpu_valid  = (state != EMPTY);

   // Ready depends only on registered occupancy, never on cpu_ready.
   assign pkt_ready = rst && !flush && (count < CW'(DEPTH));
   assign accept    = pkt_valid && pkt_ready;
   assign hit       = (pkt_in[63:48] == my_x) && (pkt_in[47:32] == my_y);
   assign push      = accept && hit;
   assign pop       = cpu_valid && cpu_ready;

   always_comb begin
      cnt_nxt = count;
      if (push && !pop)
         cnt_nxt = count + 1'b1;
      else if (pop && !push)
         cnt_nxt = count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= pkt_in[31:0];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         state    <= EMPTY;
         cpu_data <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         state  <= EMPTY;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_nxt;
         count <= cnt_nxt;
         unique case (1'b1)
            (cnt_nxt == '0):         state <= EMPTY;
            (cnt_nxt == CW'(DEPTH)): state <= FULL;
            default:                 state <= PARTIAL;
         endcase
         // cpu_data is a register tracking the next head.
         if (push && (count == '0 || (pop && count == CW'(1))))
            cpu_data <= pkt_in[31:0];
         else if (pop && count > CW'(1))
            cpu_data <= mem[rd_nxt];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)
         drop_cnt <= '0;
      else if (accept && !hit && drop_cnt != '1)
         drop_cnt <= drop_cnt + 1'b1;
   end

endmodule

// File: tb/tb_net_rx_iface.sv
// Bench for net_rx_iface: directed scenarios plus random traffic,
// compared against a queue-based model of the receive path.
module tb_net_rx_iface;

   localparam int DEPTH = 4;
   localparam int MAXD  = 255;

   logic        clk;
   logic        rst;
   logic [15:0] my_x;
   logic [15:0] my_y;
   logic [63:0] pkt_in;
   logic        pkt_valid;
   logic        pkt_ready;
   logic [31:0] cpu_data;
   logic        cpu_valid;
   logic        cpu_ready;
   logic        flush;
   logic [2:0]  fifo_count;
   logic [7:0]  drop_cnt;

   net_rx_iface #(.DEPTH(DEPTH), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .my_x       (my_x),
      .my_y       (my_y),
      .pkt_in     (pkt_in),
      .pkt_valid  (pkt_valid),
      .pkt_ready  (pkt_ready),
      .cpu_data   (cpu_data),
      .cpu_valid  (cpu_valid),
      .cpu_ready  (cpu_ready),
      .flush      (flush),
      .fifo_count (fifo_count),
      .drop_cnt   (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          compared = 0;
   int          mism = 0;
   logic [31:0] q[$];
   int          drops = 0;
   logic [31:0] last_data = '0;
   logic        last_acc;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mism++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mk(input logic [15:0] x,
                                      input logic [15:0] y,
                                      input logic [31:0] d);
      return {x, y, d};
   endfunction

   task automatic cycle(input logic r, input logic f, input logic pv,
                        input logic [63:0] p, input logic cr,
                        input string tag);
      logic exp_rdy;
      logic hit;
      rst = r;
      flush = f;
      pkt_valid = pv;
      pkt_in = p;
      cpu_ready = cr;
      #1;
      exp_rdy = r && !f && (q.size() < DEPTH);
      chk({tag, ".rdy"}, {63'd0, pkt_ready}, {63'd0, exp_rdy});
      @(posedge clk);
      last_acc = 1'b0;
      hit = (p[63:48] == my_x) && (p[47:32] == my_y);
      if (!r) begin
         q.delete();
         drops = 0;
         last_data = '0;
      end else if (f) begin
         q.delete();
      end else begin
         if (q.size() > 0 && cr)
            void'(q.pop_front());
         if (pv && exp_rdy) begin
            last_acc = 1'b1;
            if (hit)
               q.push_back(p[31:0]);
            else if (drops < MAXD)
               drops++;
         end
      end
      if (q.size() > 0)
         last_data = q[0];
      #1;
      chk({tag, ".cnt"}, {61'd0, fifo_count}, 64'(q.size()));
      chk({tag, ".vld"}, {63'd0, cpu_valid}, {63'd0, q.size() > 0});
      chk({tag, ".dat"}, {32'd0, cpu_data}, {32'd0, last_data});
      chk({tag, ".drp"}, {56'd0, drop_cnt}, 64'(drops));
   endtask

   initial begin
      logic [63:0] p;
      my_x = 16'd2;
      my_y = 16'd2;
      rst = 1'b0;
      flush = 1'b0;
      pkt_valid = 1'b0;
      pkt_in = '0;
      cpu_ready = 1'b0;
      @(posedge clk);
      #1;
      cycle(0, 0, 1, mk(2, 2, 32'h1111), 0, "reset0");
      cycle(0, 0, 0, '0, 0, "reset1");
      cycle(1, 0, 0, '0, 0, "idle");

      // Single matching packet with CPU ready.
      cycle(1, 0, 1, 64'h0002_0002_DEADBEEF, 1, "m31a");
      chk("m31.data", {32'd0, cpu_data}, 64'hDEADBEEF);
      cycle(1, 0, 0, '0, 1, "m31b");
      chk("m31.empty", {61'd0, fifo_count}, 64'd0);

      // Misaddressed packets and counter saturation.
      cycle(1, 0, 1, 64'h0003_0002_12345678, 1, "m32a");
      chk("m32.one", {56'd0, drop_cnt}, 64'd1);
      for (int i = 0; i < 300; i++)
         cycle(1, 0, 1, mk(16'd3, 16'(i), 32'(i)), 1, "m32s");
      chk("m32.sat", {56'd0, drop_cnt}, 64'd255);

      // Fill while CPU stalls; fifth packet waits.
      for (int i = 1; i <= 5; i++)
         cycle(1, 0, 1, mk(2, 2, 32'(i)), 0, "m33f");
      chk("m33.full", {61'd0, fifo_count}, 64'd4);
      chk("m33.nrdy", {63'd0, pkt_ready}, 64'd0);
      chk("m33.head", {32'd0, cpu_data}, 64'd1);
      last_acc = 1'b0;
      for (int k = 0; k < 4 && !last_acc; k++)
         cycle(1, 0, 1, mk(2, 2, 32'd5), 1, "m33r");
      chk("m33.acc5", {63'd0, last_acc}, 64'd1);
      for (int i = 0; i < 5; i++)
         cycle(1, 0, 0, '0, 1, "m33d");

      // Simultaneous push and pop across pointer wrap.
      cycle(1, 0, 1, mk(2, 2, 32'h100), 0, "m34p");
      cycle(1, 0, 1, mk(2, 2, 32'h101), 0, "m34p");
      for (int i = 0; i < 10; i++)
         cycle(1, 0, 1, mk(2, 2, 32'h200 + 32'(i)), 1, "m34w");
      chk("m34.cnt", {61'd0, fifo_count}, 64'd2);
      chk("m34.head", {32'd0, cpu_data}, 64'h208);
      for (int i = 0; i < 3; i++)
         cycle(1, 0, 0, '0, 1, "m34d");

      // Flush with a pending pop and pending packet.
      for (int i = 0; i < 3; i++)
         cycle(1, 0, 1, mk(2, 2, 32'h300 + 32'(i)), 0, "m35p");
      cycle(1, 1, 1, mk(2, 2, 32'h3FF), 1, "m35f");
      chk("m35.cnt", {61'd0, fifo_count}, 64'd0);
      chk("m35.drp", {56'd0, drop_cnt}, 64'd255);
      cycle(1, 0, 0, '0, 1, "m35i");

      // Reset mid-stream.
      cycle(0, 0, 0, '0, 0, "m36r0");
      for (int i = 0; i < 7; i++)
         cycle(1, 0, 1, mk(9, 9, 32'(i)), 0, "m36m");
      for (int i = 0; i < 3; i++)
         cycle(1, 0, 1, mk(2, 2, 32'h400 + 32'(i)), 0, "m36p");
      chk("m36.drp7", {56'd0, drop_cnt}, 64'd7);
      cycle(0, 0, 1, mk(2, 2, 32'h4FF), 1, "m36r");
      chk("m36.dat0", {32'd0, cpu_data}, 64'd0);
      cycle(1, 0, 0, '0, 0, "m36rel");

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) < 5) begin
            my_x = 16'($urandom_range(1, 4));
            my_y = 16'($urandom_range(1, 4));
         end
         if ($urandom_range(0, 3) != 0)
            p = mk(my_x, my_y, $urandom);
         else
            p = mk(16'($urandom_range(1, 4)),
                   16'($urandom_range(1, 4)), $urandom);
         cycle($urandom_range(0, 63) != 0,
               $urandom_range(0, 15) == 0,
               $urandom_range(0, 2) != 0, p,
               $urandom_range(0, 1) == 1, "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mism);
      $finish;
   end

endmodule
